// File: rtl/instr_mem_port.sv
// Instruction RAM port: boot-loader write streaming in LOAD, core fetch with gnt/rvalid in RUN.
// Optional macro INSTR_MEM_PORT_RANGE_CHECK_EN enables out-of-range fetch detection.
module instr_mem_port #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BOOT_LOAD  = 1,
  localparam int unsigned RAM_WORDS = RAM_SIZE / 4,
  localparam int unsigned AW        = $clog2(RAM_WORDS),
  localparam int unsigned CW        = AW + 1,
  localparam int unsigned IDX       = $clog2(RAM_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [31:0]           instr_rdata_o,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [31:0]           ld_data_i,
  input  logic                  ld_done_i,
  output logic [CW-1:0]         ld_count_o,
  output logic                  ld_ovf_o,
  output logic                  running_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  fetch_err_o
);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam state_t        RST_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
  localparam logic [CW-1:0] FULL      = CW'(RAM_WORDS);

  state_t        state_q, state_d;
  logic [CW-1:0] ld_count_q;
  logic          ld_ovf_q;
  logic          rvalid_q;
  logic          fetch_oor;
  logic          oor_resp;
  logic          unused_bits;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD && ld_done_i) begin
      state_d = ST_RUN;
    end
  end

  // Combinational outputs are forced idle while reset is held so nothing leaks out mid-reset.
  always_comb begin
    instr_gnt_o = 1'b0;
    ld_ready_o  = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = ld_count_q[AW-1:0];
    ram_wdata_o = ld_data_i;
    fetch_oor   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_LOAD: begin
          ld_ready_o = (ld_count_q < FULL);
          if (ld_valid_i && ld_ready_o) begin
            ram_en_o = 1'b1;
            ram_we_o = 1'b1;
          end
        end
        ST_RUN: begin
          instr_gnt_o = instr_req_i;
          ram_addr_o  = instr_addr_i[IDX-1:2];
`ifdef INSTR_MEM_PORT_RANGE_CHECK_EN
          fetch_oor   = instr_req_i & (|instr_addr_i[ADDR_WIDTH-1:IDX]);
`endif
          ram_en_o    = instr_req_i & ~fetch_oor;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_count_q <= '0;
      ld_ovf_q   <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      if (ram_we_o) begin
        ld_count_q <= ld_count_q + CW'(1);
      end
      if (state_q == ST_LOAD && ld_valid_i && !ld_ready_o) begin
        ld_ovf_q <= 1'b1;
      end
      rvalid_q <= instr_gnt_o;
    end
  end

`ifdef INSTR_MEM_PORT_RANGE_CHECK_EN
  logic oor_q;
  logic fetch_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      oor_q       <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      oor_q <= fetch_oor;
      if (fetch_oor) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  assign oor_resp    = oor_q;
  assign fetch_err_o = fetch_err_q;
  assign unused_bits = ^instr_addr_i[1:0];
`else
  assign oor_resp    = 1'b0;
  assign fetch_err_o = 1'b0;
  assign unused_bits = ^{instr_addr_i[ADDR_WIDTH-1:IDX], instr_addr_i[1:0]};
`endif

  // Out-of-range fetches answer with an all-zero word, which decodes as an illegal instruction.
  assign instr_rvalid_o = rvalid_q & ~reset;
  assign instr_rdata_o  = (instr_rvalid_o && !oor_resp) ? ram_rdata_i : '0;
  assign ld_count_o     = ld_count_q;
  assign ld_ovf_o       = ld_ovf_q;
  assign running_o      = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem_port.sv
// Directed bench for instr_mem_port: vector table plus hand-written reset/load-done sequences.
module tb_instr_mem_port;

`ifdef INSTR_MEM_PORT_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic [31:0] addr  = '0;
  logic        valid = 1'b0;
  logic [31:0] data  = '0;
  logic        done  = 1'b0;

  logic        gnt, rvalid, ready, ovf, running, en, we, err;
  logic [31:0] rdata, wdata, ram_rdata;
  logic [2:0]  count;
  logic [1:0]  raddr;

  logic        r_gnt, r_rvalid, r_ready, r_ovf, r_running, r_en, r_we, r_err;
  logic [31:0] r_rdata, r_wdata;
  logic [2:0]  r_count;
  logic [1:0]  r_raddr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instr_mem_port #(.RAM_SIZE(16), .ADDR_WIDTH(32), .BOOT_LOAD(1)) dut (
    .clock(clock), .reset(reset),
    .instr_req_i(req), .instr_gnt_o(gnt), .instr_rvalid_o(rvalid),
    .instr_addr_i(addr), .instr_rdata_o(rdata),
    .ld_valid_i(valid), .ld_ready_o(ready), .ld_data_i(data), .ld_done_i(done),
    .ld_count_o(count), .ld_ovf_o(ovf), .running_o(running),
    .ram_en_o(en), .ram_we_o(we), .ram_addr_o(raddr), .ram_wdata_o(wdata),
    .ram_rdata_i(ram_rdata), .fetch_err_o(err)
  );

  instr_mem_port #(.RAM_SIZE(16), .ADDR_WIDTH(32), .BOOT_LOAD(0)) dut_run (
    .clock(clock), .reset(reset),
    .instr_req_i(req), .instr_gnt_o(r_gnt), .instr_rvalid_o(r_rvalid),
    .instr_addr_i(addr), .instr_rdata_o(r_rdata),
    .ld_valid_i(valid), .ld_ready_o(r_ready), .ld_data_i(data), .ld_done_i(done),
    .ld_count_o(r_count), .ld_ovf_o(r_ovf), .running_o(r_running),
    .ram_en_o(r_en), .ram_we_o(r_we), .ram_addr_o(r_raddr), .ram_wdata_o(r_wdata),
    .ram_rdata_i(32'h0), .fetch_err_o(r_err)
  );

  // Behavioural 4-word RAM with one-cycle read latency.
  logic [31:0] mem [4];
  always @(posedge clock) begin
    if (en) begin
      if (we) mem[raddr] <= wdata;
      else    ram_rdata  <= mem[raddr];
    end
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        done;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        en;
    logic        we;
    logic [1:0]  raddr;
    logic [2:0]  count;
    logic        run;
    logic        ovf;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic rq, logic [31:0] a, logic v, logic [31:0] d, logic dn,
                              logic g, logic rv, logic [31:0] rd, logic rdy, logic e, logic w,
                              logic [1:0] ra, logic [2:0] c, logic rn, logic o, logic er);
    vec_t t;
    t.req = rq; t.addr = a; t.valid = v; t.data = d; t.done = dn;
    t.gnt = g; t.rvalid = rv; t.rdata = rd; t.ready = rdy; t.en = e; t.we = w;
    t.raddr = ra; t.count = c; t.run = rn; t.ovf = o; t.err = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              req addr   vld data   dn | gnt rv rdata  rdy en    we raddr cnt run ovf err
    vecs[0]  = mk(1, 32'h00, 1, 32'h11, 0,  0, 0, 32'h00,  1, 1,    1, 2'd0, 3'd0, 0, 0, 0);
    vecs[1]  = mk(1, 32'h00, 1, 32'h22, 0,  0, 0, 32'h00,  1, 1,    1, 2'd1, 3'd1, 0, 0, 0);
    vecs[2]  = mk(1, 32'h00, 1, 32'h33, 0,  0, 0, 32'h00,  1, 1,    1, 2'd2, 3'd2, 0, 0, 0);
    vecs[3]  = mk(1, 32'h00, 1, 32'h44, 0,  0, 0, 32'h00,  1, 1,    1, 2'd3, 3'd3, 0, 0, 0);
    vecs[4]  = mk(1, 32'h00, 1, 32'h66, 0,  0, 0, 32'h00,  0, 0,    0, 2'd0, 3'd4, 0, 0, 0);
    vecs[5]  = mk(1, 32'h00, 0, 32'h00, 1,  0, 0, 32'h00,  0, 0,    0, 2'd0, 3'd4, 0, 1, 0);
    vecs[6]  = mk(1, 32'h00, 0, 32'h00, 0,  1, 0, 32'h00,  0, 1,    0, 2'd0, 3'd4, 1, 1, 0);
    vecs[7]  = mk(1, 32'h04, 0, 32'h00, 0,  1, 1, 32'h11,  0, 1,    0, 2'd1, 3'd4, 1, 1, 0);
    vecs[8]  = mk(1, 32'h08, 0, 32'h00, 0,  1, 1, 32'h22,  0, 1,    0, 2'd2, 3'd4, 1, 1, 0);
    vecs[9]  = mk(0, 32'h08, 0, 32'h00, 0,  0, 1, 32'h33,  0, 0,    0, 2'd2, 3'd4, 1, 1, 0);
    vecs[10] = mk(1, 32'h10, 0, 32'h00, 0,  1, 0, 32'h00,  0, !RC,  0, 2'd0, 3'd4, 1, 1, 0);
    vecs[11] = mk(0, 32'h00, 0, 32'h00, 0,  0, 1, RC ? 32'h0 : 32'h11,
                                                           0, 0,    0, 2'd0, 3'd4, 1, 1, RC);
    vecs[12] = mk(0, 32'h00, 1, 32'h77, 1,  0, 0, 32'h00,  0, 0,    0, 2'd0, 3'd4, 1, 1, RC);

    // Reset held with req=1: every output at its reset value.
    req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_gnt", {31'b0, gnt}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_count", {29'b0, count}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_en", {31'b0, en}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_running", {31'b0, running}, 32'h0);
    chk("rst_run_running", {31'b0, r_running}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      reset = 1'b0;
      req   = vecs[i].req;
      addr  = vecs[i].addr;
      valid = vecs[i].valid;
      data  = vecs[i].data;
      done  = vecs[i].done;
      #1;
      chk($sformatf("v%0d_gnt", i), {31'b0, gnt}, {31'b0, vecs[i].gnt});
      chk($sformatf("v%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].rvalid});
      if (vecs[i].rvalid) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("v%0d_ready", i), {31'b0, ready}, {31'b0, vecs[i].ready});
      chk($sformatf("v%0d_en", i), {31'b0, en}, {31'b0, vecs[i].en});
      chk($sformatf("v%0d_we", i), {31'b0, we}, {31'b0, vecs[i].we});
      if (vecs[i].en) chk($sformatf("v%0d_raddr", i), {30'b0, raddr}, {30'b0, vecs[i].raddr});
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), wdata, vecs[i].data);
      chk($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, vecs[i].count});
      chk($sformatf("v%0d_running", i), {31'b0, running}, {31'b0, vecs[i].run});
      chk($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_run_ready", i), {31'b0, r_ready}, 32'h0);
      chk($sformatf("v%0d_run_gnt", i), {31'b0, r_gnt}, {31'b0, vecs[i].req});
    end

    // Reset the cycle after a granted fetch: its rvalid must never appear.
    @(negedge clock);
    req = 1'b1; addr = 32'h4; valid = 1'b0; done = 1'b0;
    #1 chk("abort_gnt", {31'b0, gnt}, 32'h1);
    @(negedge clock);
    reset = 1'b1; req = 1'b0;
    #1 chk("abort_rvalid_in_reset", {31'b0, rvalid}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_rvalid_after", {31'b0, rvalid}, 32'h0);
    chk("abort_running", {31'b0, running}, 32'h0);
    chk("abort_count", {29'b0, count}, 32'h0);
    chk("abort_ready", {31'b0, ready}, 32'h1);

    // Reset in the middle of a load restarts the word count.
    @(negedge clock); valid = 1'b1; data = 32'hA0;
    @(negedge clock); data = 32'hA1;
    @(negedge clock); valid = 1'b0;
    #1 chk("midload_count", {29'b0, count}, 32'h2);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    #1;
    chk("midload_rst_count", {29'b0, count}, 32'h0);
    chk("midload_rst_ready", {31'b0, ready}, 32'h1);
    chk("midload_rst_running", {31'b0, running}, 32'h0);

    // ld_done together with a final word: the word is still written, then RUN.
    @(negedge clock); valid = 1'b1; data = 32'h11;
    @(negedge clock); data = 32'h22;
    @(negedge clock); data = 32'h55; done = 1'b1;
    #1;
    chk("done_we", {31'b0, we}, 32'h1);
    chk("done_raddr", {30'b0, raddr}, 32'h2);
    chk("done_wdata", wdata, 32'h55);
    @(negedge clock); data = 32'h99; done = 1'b0; req = 1'b1; addr = 32'h8;
    #1;
    chk("done_running", {31'b0, running}, 32'h1);
    chk("done_count", {29'b0, count}, 32'h3);
    chk("done_late_ready", {31'b0, ready}, 32'h0);
    chk("done_late_we", {31'b0, we}, 32'h0);
    chk("done_fetch_gnt", {31'b0, gnt}, 32'h1);
    @(negedge clock); valid = 1'b0; req = 1'b0;
    #1;
    chk("done_fetch_rvalid", {31'b0, rvalid}, 32'h1);
    chk("done_fetch_rdata", rdata, 32'h55);
    chk("done_count_hold", {29'b0, count}, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
